// File: rtl/trace_capture_pkg.sv
// Shared register offsets, FSM encoding and CTRL bit positions for trace_capture.
package trace_capture_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_TRIG_VAL  = 3'd2;
  localparam logic [2:0] REG_TRIG_MASK = 3'd3;
  localparam logic [2:0] REG_PRETRIG   = 3'd4;
  localparam logic [2:0] REG_RD_ADR    = 3'd5;
  localparam logic [2:0] REG_RD_DATA   = 3'd6;
  localparam logic [2:0] REG_TRIG_POS  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_FORCE = 2;
  localparam int CTRL_EDGE  = 3;

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no reset.
module trace_capture_ram #(
  parameter int width     = 16,
  parameter int adr_width = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [adr_width-1:0] wadr_i,
  input  logic [width-1:0]     wdata_i,
  input  logic [adr_width-1:0] radr_i,
  output logic [width-1:0]     rdata_o
);

  logic [width-1:0] mem_q [0:(1<<adr_width)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wadr_i] <= wdata_i;
    rdata_o <= mem_q[radr_i];
  end

endmodule

// File: rtl/trace_capture.sv
// Probe capture engine with pre-trigger depth and masked value trigger, CSR-controlled.
// Optional edge-trigger mode is built in when TRACE_CAPTURE_EDGE_TRIG_EN is defined.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter logic [3:0] csr_addr  = 4'h1,
  parameter int         width     = 16,
  parameter int         adr_width = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [13:0]      csr_a,
  input  logic             csr_we,
  input  logic [31:0]      csr_di,
  output logic [31:0]      csr_do,
  input  logic [width-1:0] probe,
  output logic             done_irq
);

  localparam logic [adr_width:0]   DEPTH_W = {1'b1, {adr_width{1'b0}}};
  localparam logic [adr_width:0]   ONE_W   = {{adr_width{1'b0}}, 1'b1};
  localparam logic [adr_width-1:0] MAX_ADR = {adr_width{1'b1}};

  state_e               state_q, state_d;
  logic [width-1:0]     p_q, trig_val_q, trig_mask_q, ram_rdata;
  logic [adr_width-1:0] pretrig_q, rd_adr_q, ram_radr;
  logic [adr_width-1:0] wptr_q, wptr_d, trig_pos_q, trig_pos_d;
  logic [adr_width:0]   cnt_q, cnt_d, cnt_inc, post_len;
  logic                 done_q, done_d, trig_q, trig_d, irq_q, irq_d;
  logic [31:0]          csr_do_q, rd_mux;
  logic                 sel, wr, wr_ctrl, cfg_ok, arm, abort, force_trig;
  logic                 match, trig_hit, ram_we;
  logic                 unused_csr_a;

  assign unused_csr_a = ^csr_a[9:3];

  assign sel        = (csr_a[13:10] == csr_addr);
  assign wr         = sel && csr_we;
  assign wr_ctrl    = wr && (csr_a[2:0] == REG_CTRL);
  assign cfg_ok     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign arm        = wr_ctrl && csr_di[CTRL_ARM];
  assign abort      = wr_ctrl && csr_di[CTRL_ABORT];
  assign force_trig = wr_ctrl && csr_di[CTRL_FORCE];

  assign match    = ((p_q ^ trig_val_q) & trig_mask_q) == '0;
  assign cnt_inc  = cnt_q + ONE_W;
  assign post_len = DEPTH_W - {1'b0, pretrig_q};
  // Window starts PRETRIG samples before the trigger and wraps with the buffer.
  assign ram_radr = trig_pos_q - pretrig_q + rd_adr_q;

`ifdef TRACE_CAPTURE_EDGE_TRIG_EN
  logic edge_q, prev_match_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      edge_q       <= 1'b0;
      prev_match_q <= 1'b0;
    end else begin
      prev_match_q <= match;
      if (wr_ctrl && cfg_ok) edge_q <= csr_di[CTRL_EDGE];
    end
  end

  assign trig_hit = match && !(edge_q && prev_match_q);
`else
  assign trig_hit = match;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      cnt_q      <= '0;
      trig_pos_q <= '0;
      done_q     <= 1'b0;
      trig_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      trig_pos_q <= trig_pos_d;
      done_q     <= done_d;
      trig_q     <= trig_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    trig_pos_d = trig_pos_q;
    done_d     = done_q;
    trig_d     = trig_q;
    irq_d      = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      trig_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d = ST_PRE;
            wptr_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            trig_d  = 1'b0;
          end
        end
        ST_PRE: begin
          if (pretrig_q == '0) begin
            state_d = ST_WAIT;
          end else begin
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_inc;
            if (cnt_inc == {1'b0, pretrig_q}) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          wptr_d = wptr_q + 1'b1;
          if (trig_hit || force_trig) begin
            trig_pos_d = wptr_q;
            trig_d     = 1'b1;
            cnt_d      = ONE_W;
            // With PRETRIG = depth-1 the trigger sample alone completes the buffer.
            if (post_len == ONE_W) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == post_len) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we = ((state_q == ST_PRE) && (pretrig_q != '0)) ||
             (state_q == ST_WAIT) || (state_q == ST_POST);
  end

  assign done_irq = irq_q;
  assign csr_do   = csr_do_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_q         <= '0;
      trig_val_q  <= '0;
      trig_mask_q <= '0;
      pretrig_q   <= '0;
      rd_adr_q    <= '0;
      csr_do_q    <= '0;
    end else begin
      p_q <= probe;
      if (wr) begin
        case (csr_a[2:0])
          REG_TRIG_VAL:  if (cfg_ok) trig_val_q  <= csr_di[width-1:0];
          REG_TRIG_MASK: if (cfg_ok) trig_mask_q <= csr_di[width-1:0];
          REG_PRETRIG:   if (cfg_ok) pretrig_q   <= (csr_di > 32'(MAX_ADR)) ? MAX_ADR
                                                                            : csr_di[adr_width-1:0];
          REG_RD_ADR:    rd_adr_q <= csr_di[adr_width-1:0];
          default: ;
        endcase
      end
      csr_do_q <= sel ? rd_mux : '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_a[2:0])
`ifdef TRACE_CAPTURE_EDGE_TRIG_EN
      REG_CTRL:      rd_mux[CTRL_EDGE] = edge_q;
`else
      REG_CTRL:      rd_mux = '0;
`endif
      REG_STATUS:    rd_mux = {27'd0, trig_q, done_q, state_q};
      REG_TRIG_VAL:  rd_mux = 32'(trig_val_q);
      REG_TRIG_MASK: rd_mux = 32'(trig_mask_q);
      REG_PRETRIG:   rd_mux = 32'(pretrig_q);
      REG_RD_ADR:    rd_mux = 32'(rd_adr_q);
      REG_RD_DATA:   rd_mux = 32'(ram_rdata);
      REG_TRIG_POS:  rd_mux = 32'(trig_pos_q);
      default:       rd_mux = '0;
    endcase
  end

  trace_capture_ram #(
    .width     (width),
    .adr_width (adr_width)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (ram_we),
    .wadr_i  (wptr_q),
    .wdata_i (p_q),
    .radr_i  (ram_radr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_trace_capture.sv
// Directed and randomized bench for trace_capture (16-entry buffer, 16-bit probe).
module tb_trace_capture;
  import trace_capture_pkg::*;

  localparam int DEPTH = 16;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a     = '0;
  logic        csr_we    = 1'b0;
  logic [31:0] csr_di    = '0;
  logic [31:0] csr_do;
  logic [15:0] probe     = '0;
  logic        done_irq;

  int checks   = 0;
  int failures = 0;
  int irq_cnt  = 0;
  int irq_edge = -1;
  int pmode    = 0;
  logic [15:0] hist[$];

  trace_capture #(
    .csr_addr  (4'h1),
    .width     (16),
    .adr_width (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .probe     (probe),
    .done_irq  (done_irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // hist[k] is the probe value seen at clock edge k; p_q holds it after that edge.
  task automatic step();
    @(posedge sys_clk);
    hist.push_back(probe);
    #1;
    if (done_irq === 1'b1) begin
      irq_cnt++;
      irq_edge = hist.size() - 1;
    end
    case (pmode)
      1: probe = probe + 16'd1;
      2: probe = 16'($urandom);
      default: ;
    endcase
  endtask

  function automatic int edge_now();
    return hist.size() - 1;
  endfunction

  task automatic csr_wr(input logic [2:0] r, input logic [31:0] d);
    csr_a  = {4'h1, 7'd0, r};
    csr_di = d;
    csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] page, input logic [2:0] r, output logic [31:0] d);
    csr_a  = {page, 7'd0, r};
    csr_we = 1'b0;
    step();
    step();
    d = csr_do;
  endtask

  function automatic bit hit(input logic [15:0] v, input logic [15:0] val, input logic [15:0] mask);
    return ((v ^ val) & mask) == 16'd0;
  endfunction

  // First sample eligible for triggering: after PRETRIG pre-samples, or one idle PRE cycle.
  function automatic int find_trig(input int a, input int p, input logic [15:0] val,
                                   input logic [15:0] mask, input bit edge_m);
    int k;
    k = (p > 0) ? a + p : a + 1;
    while (k < hist.size()) begin
      if (hit(hist[k], val, mask) && (!edge_m || !hit(hist[k-1], val, mask))) return k;
      k++;
    end
    return -1;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int s, n;
    s = irq_cnt;
    n = 0;
    while (irq_cnt == s && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_irq"}, irq_cnt - s, 1);
  endtask

  task automatic verify(input string tag, input int a, input int p, input int t);
    logic [31:0] d;
    int off;
    if (t < 0) begin
      checks++;
      failures++;
      $error("FAIL %s_trig observed=none expected=a matching sample", tag);
      return;
    end
    off = (p == 0) ? 1 : 0;
    chk({tag, "_done_edge"}, irq_edge, t + DEPTH - p);
    csr_rd(4'h1, REG_TRIG_POS, d);
    chk({tag, "_trig_pos"}, d, (t - a - off) & (DEPTH - 1));
    csr_rd(4'h1, REG_STATUS, d);
    chk({tag, "_status"}, d, 32'h1C);
    for (int i = 0; i < DEPTH; i++) begin
      csr_wr(REG_RD_ADR, i);
      csr_rd(4'h1, REG_RD_DATA, d);
      chk($sformatf("%s_rd%0d", tag, i), d, {16'd0, hist[t - p + i]});
    end
  endtask

  initial begin
    logic [31:0] d;
    int a, t, s, f, p;
    logic [15:0] val, mask;

    // Reset state
    step();
    step();
    chk("rst_csr_do", csr_do, 0);
    chk("rst_irq", {31'd0, done_irq}, 0);
    sys_rst_n = 1'b1;
    csr_rd(4'h1, REG_STATUS, d);
    chk("rst_status", d, 0);

    // CTRL edge bit readback
    csr_wr(REG_CTRL, 32'h8);
    csr_rd(4'h1, REG_CTRL, d);
`ifdef TRACE_CAPTURE_EDGE_TRIG_EN
    chk("ctrl_edge_rb", d, 32'h8);
`else
    chk("ctrl_edge_rb", d, 32'h0);
`endif
    csr_wr(REG_CTRL, 32'h0);

    // Level trigger mid-buffer
    csr_wr(REG_PRETRIG, 4);
    csr_wr(REG_TRIG_MASK, 32'hFFFF);
    csr_wr(REG_TRIG_VAL, 32'h0020);
    probe = 16'd0;
    pmode = 1;
    s = irq_cnt;
    csr_wr(REG_CTRL, 32'h1);
    a = edge_now();
    wait_done("lvl", 200);
    t = find_trig(a, 4, 16'h0020, 16'hFFFF, 1'b0);
    verify("lvl", a, 4, t);
    chk("lvl_first", {16'd0, hist[t - 4]}, 32'h1C);
    chk("lvl_irq_once", irq_cnt - s, 1);

    // Mask 0, immediate trigger, PRETRIG 0
    pmode = 0;
    probe = 16'hA5A5;
    csr_wr(REG_PRETRIG, 0);
    csr_wr(REG_TRIG_MASK, 0);
    csr_wr(REG_CTRL, 32'h1);
    a = edge_now();
    wait_done("m0", 100);
    chk("m0_latency", irq_edge - a, 17);
    verify("m0", a, 0, a + 1);

    // Abort during WAIT, arm+abort together, then re-arm
    csr_wr(REG_PRETRIG, 4);
    csr_wr(REG_TRIG_MASK, 32'hFFFF);
    csr_wr(REG_TRIG_VAL, 32'hBEEF);
    probe = 16'h0000;
    s = irq_cnt;
    csr_wr(REG_CTRL, 32'h1);
    a = edge_now();
    repeat (8) step();
    csr_rd(4'h1, REG_STATUS, d);
    chk("abort_pre_state", d, 32'h2);
    csr_wr(REG_CTRL, 32'h2);
    repeat (20) step();
    csr_rd(4'h1, REG_STATUS, d);
    chk("abort_status", d, 0);
    chk("abort_no_irq", irq_cnt - s, 0);
    csr_wr(REG_CTRL, 32'h3);
    csr_rd(4'h1, REG_STATUS, d);
    chk("arm_abort_status", d, 0);
    csr_wr(REG_TRIG_VAL, 0);
    csr_wr(REG_CTRL, 32'h1);
    a = edge_now();
    wait_done("rearm", 100);
    verify("rearm", a, 4, find_trig(a, 4, 16'h0, 16'hFFFF, 1'b0));

    // Force trigger, plus ignored force in PRE and ignored mask write in WAIT
    csr_wr(REG_TRIG_VAL, 32'hFFFF);
    probe = 16'd0;
    pmode = 1;
    csr_wr(REG_CTRL, 32'h1);
    a = edge_now();
    csr_wr(REG_CTRL, 32'h4);
    repeat (6) step();
    csr_wr(REG_TRIG_MASK, 0);
    csr_rd(4'h1, REG_TRIG_MASK, d);
    chk("mask_locked", d, 32'hFFFF);
    csr_rd(4'h1, REG_STATUS, d);
    chk("force_pre_state", d, 32'h2);
    csr_wr(REG_CTRL, 32'h4);
    f = edge_now();
    wait_done("force", 100);
    verify("force", a, 4, f - 1);

    // PRETRIG clamp and unselected page
    pmode = 0;
    csr_wr(REG_PRETRIG, 32'hFFFF);
    csr_rd(4'h1, REG_PRETRIG, d);
    chk("pretrig_clamp", d, 15);
    csr_rd(4'h2, REG_PRETRIG, d);
    chk("other_page", d, 0);

    // Asynchronous reset mid-POST
    csr_wr(REG_PRETRIG, 2);
    csr_wr(REG_TRIG_MASK, 0);
    csr_wr(REG_TRIG_VAL, 32'h1234);
    probe = 16'h5A5A;
    s = irq_cnt;
    csr_wr(REG_CTRL, 32'h1);
    repeat (4) step();
    csr_rd(4'h1, REG_STATUS, d);
    chk("post_status", d, 32'h13);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_csr_do", csr_do, 0);
    chk("arst_irq", {31'd0, done_irq}, 0);
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (25) step();
    chk("arst_no_irq", irq_cnt - s, 0);
    csr_rd(4'h1, REG_STATUS, d);
    chk("arst_status", d, 0);
    csr_rd(4'h1, REG_PRETRIG, d);
    chk("arst_pretrig", d, 0);
    csr_rd(4'h1, REG_TRIG_VAL, d);
    chk("arst_val", d, 0);

`ifdef TRACE_CAPTURE_EDGE_TRIG_EN
    // Edge mode: probe matching at arm must not trigger until it leaves and returns
    csr_wr(REG_PRETRIG, 2);
    csr_wr(REG_TRIG_MASK, 32'hFFFF);
    csr_wr(REG_TRIG_VAL, 32'h1234);
    probe = 16'h1234;
    csr_wr(REG_CTRL, 32'h9);
    a = edge_now();
    repeat (15) step();
    csr_rd(4'h1, REG_STATUS, d);
    chk("edge_hold_state", d, 32'h2);
    probe = 16'h0000;
    repeat (3) step();
    probe = 16'h1234;
    wait_done("edge", 100);
    t = find_trig(a, 2, 16'h1234, 16'hFFFF, 1'b1);
    verify("edge", a, 2, t);
    csr_wr(REG_CTRL, 32'h0);
`endif

    // Randomized captures against the sample-history model
    for (int it = 0; it < 6; it++) begin
      p    = $urandom_range(0, DEPTH - 1);
      mask = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      if (it == 2) mask = 16'd0;
      val  = 16'($urandom);
      pmode = 2;
      csr_wr(REG_TRIG_VAL, {16'd0, val});
      csr_wr(REG_TRIG_MASK, {16'd0, mask});
      csr_wr(REG_PRETRIG, p);
      csr_wr(REG_CTRL, 32'h1);
      a = edge_now();
      wait_done($sformatf("rnd%0d", it), 300);
      verify($sformatf("rnd%0d", it), a, p, find_trig(a, p, val, mask, 1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
